// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC sequencer with return-address stack; PC_SEQ_HALT_ON_ERROR_EN adds a HALT state on stack errors
module pc_sequencer #(
    parameter int ADDR_WIDTH  = 16,
    parameter int STACK_DEPTH = 8
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          iStall,
    input  logic                          iJump,
    input  logic                          iCall,
    input  logic                          iRet,
    input  logic [ADDR_WIDTH-1:0]         iTarget,
    output logic [ADDR_WIDTH-1:0]         oAddress,
    output logic [$clog2(STACK_DEPTH):0]  oStackDepth,
    output logic                          oOverflow,
    output logic                          oUnderflow,
    output logic                          oHalted
);

    localparam int PTR_W   = $clog2(STACK_DEPTH);
    localparam int DEPTH_W = PTR_W + 1;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE     = ADDR_WIDTH'(1);
    localparam logic [DEPTH_W-1:0]    DEPTH_ONE  = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0]    DEPTH_FULL = DEPTH_W'(STACK_DEPTH);
    localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [DEPTH_W-1:0]    depth;
    logic [DEPTH_W-1:0]    depth_next;
    logic                  overflow;
    logic                  underflow;
    logic                  overflow_set;
    logic                  underflow_set;
    logic                  push;
    logic                  frozen;
    logic                  stack_full;
    logic                  stack_empty;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

    assign pc_inc      = pc + PC_ONE;
    assign stack_full  = (depth == DEPTH_FULL);
    assign stack_empty = (depth == '0);
    // A full stack wraps wr_ptr to 0, so rd_ptr still lands on the last entry.
    assign wr_ptr      = depth[PTR_W-1:0];
    assign rd_ptr      = wr_ptr - PTR_ONE;

`ifdef PC_SEQ_HALT_ON_ERROR_EN
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0] state;
    logic [0:0] state_next;
    logic       error;

    assign error  = overflow_set | underflow_set;
    assign frozen = (state == ST_HALT);

    always_comb begin
        state_next = state;
        if (error) begin
            state_next = ST_HALT;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    assign oHalted = (state == ST_HALT);
`else
    assign frozen  = 1'b0;
    assign oHalted = 1'b0;
`endif

    // Priority: halt, stall, ret, call, jump, increment. Errors fall back to PC+1.
    always_comb begin
        pc_next       = pc_inc;
        depth_next    = depth;
        push          = 1'b0;
        overflow_set  = 1'b0;
        underflow_set = 1'b0;
        if (frozen) begin
            pc_next = pc;
        end else if (iStall) begin
            pc_next = pc;
        end else if (iRet) begin
            if (stack_empty) begin
                underflow_set = 1'b1;
            end else begin
                pc_next    = stack_mem[rd_ptr];
                depth_next = depth - DEPTH_ONE;
            end
        end else if (iCall) begin
            if (stack_full) begin
                overflow_set = 1'b1;
            end else begin
                push       = 1'b1;
                depth_next = depth + DEPTH_ONE;
                pc_next    = iTarget;
            end
        end else if (iJump) begin
            pc_next = iTarget;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc        <= '0;
            depth     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pc        <= pc_next;
            depth     <= depth_next;
            overflow  <= overflow | overflow_set;
            underflow <= underflow | underflow_set;
        end
    end

    // Stack storage is deliberately left uninitialised; only depth is reset.
    always_ff @(posedge Clock) begin
        if (push && !Reset) begin
            stack_mem[wr_ptr] <= pc_inc;
        end
    end

    assign oAddress    = pc;
    assign oStackDepth = depth;
    assign oOverflow   = overflow;
    assign oUnderflow  = underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iStall;
    logic        iJump;
    logic        iCall;
    logic        iRet;
    logic [15:0] iTarget;
    logic [15:0] oAddress;
    logic [3:0]  oStackDepth;
    logic        oOverflow;
    logic        oUnderflow;
    logic        oHalted;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(
        .ADDR_WIDTH  (16),
        .STACK_DEPTH (8)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .iStall      (iStall),
        .iJump       (iJump),
        .iCall       (iCall),
        .iRet        (iRet),
        .iTarget     (iTarget),
        .oAddress    (oAddress),
        .oStackDepth (oStackDepth),
        .oOverflow   (oOverflow),
        .oUnderflow  (oUnderflow),
        .oHalted     (oHalted)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic strobes(input logic s, input logic j, input logic c, input logic r, input logic [15:0] t);
        iStall  = s;
        iJump   = j;
        iCall   = c;
        iRet    = r;
        iTarget = t;
    endtask

    task automatic idle();
        strobes(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("rst_addr", oAddress, 0);
        check("rst_depth", oStackDepth, 0);
        check("rst_ovf", oOverflow, 0);
        check("rst_unf", oUnderflow, 0);
        check("rst_halt", oHalted, 0);
    endtask

    logic [15:0] ret_exp [8];

    initial begin
        Reset = 1'b1;
        idle();
        do_reset();

        // Sequential fetch 0..3, call 222 from 3, return to 4
        for (int i = 1; i <= 3; i++) begin
            step();
            check("seq_addr", oAddress, i);
        end
        strobes(1'b0, 1'b0, 1'b1, 1'b0, 16'd222);
        step();
        check("call_addr", oAddress, 222);
        check("call_depth", oStackDepth, 1);
        idle();
        step();
        check("inc_addr", oAddress, 223);
        strobes(1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
        step();
        check("ret_addr", oAddress, 4);
        check("ret_depth", oStackDepth, 0);

        // Nested calls from PC=4 to 100+k; returns 5,101..107 in LIFO order
        ret_exp = '{16'd5, 16'd101, 16'd102, 16'd103, 16'd104, 16'd105, 16'd106, 16'd107};
        for (int k = 0; k < 8; k++) begin
            strobes(1'b0, 1'b0, 1'b1, 1'b0, 16'(100 + k));
            step();
            check("nest_call_addr", oAddress, 100 + k);
            check("nest_call_depth", oStackDepth, k + 1);
        end
        for (int k = 7; k >= 0; k--) begin
            strobes(1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
            step();
            check("nest_ret_addr", oAddress, ret_exp[k]);
            check("nest_ret_depth", oStackDepth, k);
        end
        check("nest_ovf", oOverflow, 0);
        check("nest_unf", oUnderflow, 0);

        // Fill stack: jump 42, calls to 60..66 then 50; pushes 43,61..67
        strobes(1'b0, 1'b1, 1'b0, 1'b0, 16'd42);
        step();
        check("jump_addr", oAddress, 42);
        for (int k = 0; k < 8; k++) begin
            strobes(1'b0, 1'b0, 1'b1, 1'b0, (k == 7) ? 16'd50 : 16'(60 + k));
            step();
        end
        check("fill_addr", oAddress, 50);
        check("fill_depth", oStackDepth, 8);
        strobes(1'b0, 1'b0, 1'b1, 1'b0, 16'd99);
        step();
        check("ovf_flag", oOverflow, 1);
        check("ovf_addr", oAddress, 51);
        check("ovf_depth", oStackDepth, 8);
`ifdef PC_SEQ_HALT_ON_ERROR_EN
        check("ovf_halted", oHalted, 1);
        for (int i = 0; i < 10; i++) begin
            strobes(i[0], i[1], i[0] ^ i[1], i[2], 16'd300);
            step();
            check("halt_addr", oAddress, 51);
            check("halt_flag", oHalted, 1);
        end
`else
        check("ovf_not_halted", oHalted, 0);
        ret_exp = '{16'd43, 16'd61, 16'd62, 16'd63, 16'd64, 16'd65, 16'd66, 16'd67};
        for (int k = 7; k >= 0; k--) begin
            strobes(1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
            step();
            check("drain_addr", oAddress, ret_exp[k]);
        end
        check("drain_depth", oStackDepth, 0);
        check("ovf_sticky", oOverflow, 1);
`endif
        idle();
        do_reset();

        // Underflow at PC=7
        strobes(1'b0, 1'b1, 1'b0, 1'b0, 16'd7);
        step();
        check("jump7_addr", oAddress, 7);
        strobes(1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
        step();
        check("unf_flag", oUnderflow, 1);
        check("unf_addr", oAddress, 8);
        check("unf_depth", oStackDepth, 0);
        strobes(1'b0, 1'b1, 1'b0, 1'b0, 16'd20);
        step();
`ifdef PC_SEQ_HALT_ON_ERROR_EN
        check("unf_halt_addr", oAddress, 8);
        check("unf_halted", oHalted, 1);
`else
        check("unf_jump_addr", oAddress, 20);
        check("unf_sticky", oUnderflow, 1);
`endif
        idle();
        do_reset();

        // Stall at PC=9 (jump asserted alongside must lose)
        strobes(1'b0, 1'b1, 1'b0, 1'b0, 16'd9);
        step();
        for (int i = 0; i < 3; i++) begin
            strobes(1'b1, 1'b1, 1'b1, 1'b0, 16'd77);
            step();
            check("stall_addr", oAddress, 9);
            check("stall_depth", oStackDepth, 0);
        end
        idle();
        step();
        check("post_stall_addr", oAddress, 10);
        strobes(1'b0, 1'b1, 1'b1, 1'b0, 16'd30);
        step();
        check("calljump_addr", oAddress, 30);
        check("calljump_depth", oStackDepth, 1);
        strobes(1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
        step();
        check("calljump_ret", oAddress, 11);
        strobes(1'b0, 1'b0, 1'b1, 1'b0, 16'd40);
        step();
        check("call40_addr", oAddress, 40);
        strobes(1'b0, 1'b1, 1'b1, 1'b1, 16'd90);
        step();
        check("retwins_addr", oAddress, 12);
        check("retwins_depth", oStackDepth, 0);

        // Wrap
        strobes(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF);
        step();
        check("wrap_pre", oAddress, 16'hFFFF);
        idle();
        step();
        check("wrap_addr", oAddress, 0);

        // Reset mid-operation at depth 3 with overflow set
        for (int k = 0; k < 9; k++) begin
            strobes(1'b0, 1'b0, 1'b1, 1'b0, 16'(200 + k));
            step();
        end
        check("mid_ovf", oOverflow, 1);
`ifndef PC_SEQ_HALT_ON_ERROR_EN
        for (int k = 0; k < 5; k++) begin
            strobes(1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
            step();
        end
        check("mid_depth", oStackDepth, 3);
`endif
        strobes(1'b1, 1'b0, 1'b1, 1'b0, 16'd55);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("midrst_addr", oAddress, 0);
        check("midrst_depth", oStackDepth, 0);
        check("midrst_ovf", oOverflow, 0);
        check("midrst_unf", oUnderflow, 0);
        check("midrst_halt", oHalted, 0);
        idle();
        step();
        check("midrst_run", oAddress, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
